// File: rtl/pong_game_core.sv
// Pong engine: ball/paddle state, scoring, serve delay, game FSM and a
// registered one-pixel renderer for the raster position being requested.
module pong_game_core #(
  parameter int H_ACTIVE    = 780,
  parameter int V_ACTIVE    = 480,
  parameter int BORDER      = 4,
  parameter int PADDLE_H    = 75,
  parameter int PADDLE_W    = 10,
  parameter int BALL_SIZE   = 16,
  parameter int STEP_DIV    = 91072,
  parameter int SERVE_DELAY = 67108864,
  parameter int SCORE_MAX   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic               VGA_CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [7:0]         PADDLE_A_POSITION,
  input  logic [7:0]         PADDLE_B_POSITION,
  input  logic [10:0]        PIXEL_H,
  input  logic [10:0]        PIXEL_V,
  output logic [10:0]        BALL_H,
  output logic [10:0]        BALL_V,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic [1:0]         STATE,
  output logic [2:0]         PIXEL
);

  // Playfield geometry, all in 12-bit unsigned so sums never wrap.
  localparam logic [11:0] HMAX    = 12'(H_ACTIVE - 1 - BORDER);
  localparam logic [11:0] VMAX    = 12'(V_ACTIVE - 1 - BORDER);
  localparam logic [11:0] BRD     = 12'(BORDER);
  localparam logic [11:0] WALL_LO = 12'(BORDER + 1);
  localparam logic [11:0] WALL_HI = 12'(V_ACTIVE - 2 - BORDER);
  localparam logic [11:0] PA_L    = 12'(BORDER + 6);
  localparam logic [11:0] PA_R    = 12'(BORDER + 6 + PADDLE_W);
  localparam logic [11:0] PB_R    = 12'(H_ACTIVE - 6 - BORDER);
  localparam logic [11:0] PB_L    = 12'(H_ACTIVE - 6 - BORDER - PADDLE_W);
  localparam logic [11:0] BS      = 12'(BALL_SIZE);
  localparam logic [11:0] BS_M1   = 12'(BALL_SIZE - 1);
  localparam logic [11:0] PH_M1   = 12'(PADDLE_H - 1);
  localparam logic [11:0] PAD_MAX = 12'(V_ACTIVE - 1 - BORDER - PADDLE_H);
  localparam logic [11:0] NET_L   = 12'(H_ACTIVE / 2 - 1);
  localparam logic [11:0] NET_R   = 12'(H_ACTIVE / 2);
  localparam logic [10:0] CH      = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] CV      = 11'((V_ACTIVE - BALL_SIZE) / 2);

  localparam int DLY_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DLY_W-1:0]   DLY_LOAD  = DLY_W'(SERVE_DELAY - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCORE_W-1:0] SMAX      = SCORE_W'(SCORE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SCORE_W-1:0]  score_a_q, score_a_d, score_b_q, score_b_d;
  logic [10:0]         ball_h_q, ball_h_d, ball_v_q, ball_v_d;
  logic                right_q, right_d, down_q, down_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [11:0]         pa_pos_q, pa_pos_d, pb_pos_q, pb_pos_d;
  logic [2:0]          pixel_q, pixel_d;

  logic [11:0]         pa_raw, pb_raw, bh12, bv12, ph12, pv12;
  logic [SCORE_W-1:0]  sa_inc, sb_inc;
  logic                overlap_a, overlap_b;
  logic                on_pa, on_pb, on_border, on_ball, on_net;

  assign pa_raw   = {3'b000, PADDLE_A_POSITION, 1'b0};
  assign pb_raw   = {3'b000, PADDLE_B_POSITION, 1'b0};
  assign pa_pos_d = (pa_raw > PAD_MAX) ? PAD_MAX : pa_raw;
  assign pb_pos_d = (pb_raw > PAD_MAX) ? PAD_MAX : pb_raw;

  assign bh12 = {1'b0, ball_h_q};
  assign bv12 = {1'b0, ball_v_q};
  assign ph12 = {1'b0, PIXEL_H};
  assign pv12 = {1'b0, PIXEL_V};

  // Scores stick at the maximum rather than wrapping.
  assign sa_inc = (score_a_q >= SMAX) ? SMAX : score_a_q + SCORE_W'(1);
  assign sb_inc = (score_b_q >= SMAX) ? SMAX : score_b_q + SCORE_W'(1);

  assign overlap_a = (bv12 + BS_M1 >= pa_pos_q) && (bv12 <= pa_pos_q + PH_M1);
  assign overlap_b = (bv12 + BS_M1 >= pb_pos_q) && (bv12 <= pb_pos_q + PH_M1);

  assign on_pa = (ph12 >= PA_L) && (ph12 <= PA_R) &&
                 (pv12 >= pa_pos_q) && (pv12 <= pa_pos_q + PH_M1);
  assign on_pb = (ph12 >= PB_L) && (ph12 <= PB_R) &&
                 (pv12 >= pb_pos_q) && (pv12 <= pb_pos_q + PH_M1);
  assign on_border = (ph12 <= BRD) || (ph12 >= HMAX) || (pv12 <= BRD) || (pv12 >= VMAX);
  assign on_ball = ((state_q == ST_PLAY) || (state_q == ST_OVER)) &&
                   (ph12 >= bh12) && (ph12 <= bh12 + BS_M1) &&
                   (pv12 >= bv12) && (pv12 <= bv12 + BS_M1);
  assign on_net = PIXEL_V[4] && ((ph12 == NET_L) || (ph12 == NET_R));

  // Paddle positions are resampled every clock, independent of game reset.
  always_ff @(posedge VGA_CLOCK) begin
    pa_pos_q <= pa_pos_d;
    pb_pos_q <= pb_pos_d;
  end

  // Game state register with synchronous reset.
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      score_a_q <= '0;
      score_b_q <= '0;
      ball_h_q  <= CH;
      ball_v_q  <= CV;
      right_q   <= 1'b1;
      down_q    <= 1'b1;
      step_q    <= '0;
      dly_q     <= '0;
      pixel_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      ball_h_q  <= ball_h_d;
      ball_v_q  <= ball_v_d;
      right_q   <= right_d;
      down_q    <= down_d;
      step_q    <= step_d;
      dly_q     <= dly_d;
      pixel_q   <= pixel_d;
    end
  end

  // Next-state logic: FSM, ball motion on ticks, scoring and pixel priority.
  always_comb begin
    state_d   = state_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    ball_h_d  = ball_h_q;
    ball_v_d  = ball_v_q;
    right_d   = right_q;
    down_d    = down_q;
    step_d    = step_q;
    dly_d     = dly_q;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          dly_d   = DLY_LOAD;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (dly_q == '0) begin
          state_d = ST_PLAY;
          step_d  = '0;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      ST_PLAY: begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          // Vertical: bounce off top/bottom walls.
          if (down_q) begin
            if (bv12 + BS == WALL_HI) begin
              down_d   = 1'b0;
              ball_v_d = ball_v_q - 11'd1;
            end else begin
              ball_v_d = ball_v_q + 11'd1;
            end
          end else begin
            if (bv12 == WALL_LO) begin
              down_d   = 1'b1;
              ball_v_d = ball_v_q + 11'd1;
            end else begin
              ball_v_d = ball_v_q - 11'd1;
            end
          end
          // Horizontal: paddle bounce beats miss; a miss recentres the ball.
          if (right_q) begin
            if ((bh12 + BS == PB_L) && overlap_b) begin
              right_d  = 1'b0;
              ball_h_d = ball_h_q - 11'd1;
            end else if (bh12 + BS == HMAX) begin
              score_a_d = sa_inc;
              ball_h_d  = CH;
              ball_v_d  = CV;
              down_d    = down_q;
              right_d   = 1'b1;
              if (sa_inc == SMAX) begin
                state_d = ST_OVER;
              end else begin
                dly_d   = DLY_LOAD;
                state_d = ST_SERVE;
              end
            end else begin
              ball_h_d = ball_h_q + 11'd1;
            end
          end else begin
            if ((bh12 == PA_R + 12'd1) && overlap_a) begin
              right_d  = 1'b1;
              ball_h_d = ball_h_q + 11'd1;
            end else if (bh12 == WALL_LO) begin
              score_b_d = sb_inc;
              ball_h_d  = CH;
              ball_v_d  = CV;
              down_d    = down_q;
              right_d   = 1'b0;
              if (sb_inc == SMAX) begin
                state_d = ST_OVER;
              end else begin
                dly_d   = DLY_LOAD;
                state_d = ST_SERVE;
              end
            end else begin
              ball_h_d = ball_h_q - 11'd1;
            end
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_OVER: begin
        if (START) begin
          score_a_d = '0;
          score_b_d = '0;
          ball_h_d  = CH;
          ball_v_d  = CV;
          dly_d     = DLY_LOAD;
          state_d   = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (on_pa || on_pb)  pixel_d = 3'b111;
    else if (on_border)  pixel_d = 3'b100;
    else if (on_ball)    pixel_d = 3'b001;
    else if (on_net)     pixel_d = 3'b110;
    else                 pixel_d = 3'b000;
  end

  assign BALL_H  = ball_h_q;
  assign BALL_V  = ball_v_q;
  assign SCORE_A = score_a_q;
  assign SCORE_B = score_b_q;
  assign STATE   = state_q;
  assign PIXEL   = pixel_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Self-checking bench for pong_game_core: directed scenarios plus random play,
// every cycle compared against a rule-level reference model.
module tb_pong_game_core;

  localparam int H_ACTIVE = 64, V_ACTIVE = 48, BORDER = 2, PADDLE_H = 8;
  localparam int PADDLE_W = 1, BALL_SIZE = 2, STEP_DIV = 4, SERVE_DELAY = 8;
  localparam int SCORE_MAX = 3, SCORE_W = 4;

  localparam int HMAX = H_ACTIVE - 1 - BORDER;
  localparam int VMAX = V_ACTIVE - 1 - BORDER;
  localparam int PA_L = BORDER + 6;
  localparam int PA_R = PA_L + PADDLE_W;
  localparam int PB_R = HMAX - 5;
  localparam int PB_L = PB_R - PADDLE_W;
  localparam int CH   = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int CV   = (V_ACTIVE - BALL_SIZE) / 2;

  logic               clk;
  logic               rst_i, start_i;
  logic [7:0]         pa_i, pb_i;
  logic [10:0]        ph_i, pv_i;
  logic [10:0]        ball_h_o, ball_v_o;
  logic [SCORE_W-1:0] score_a_o, score_b_o;
  logic [1:0]         state_o;
  logic [2:0]         pixel_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers, rule by rule).
  int m_st, m_sa, m_sb, m_bh, m_bv, m_right, m_down, m_step, m_dly, m_pa, m_pb, m_pix;

  pong_game_core #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BORDER(BORDER), .PADDLE_H(PADDLE_H),
    .PADDLE_W(PADDLE_W), .BALL_SIZE(BALL_SIZE), .STEP_DIV(STEP_DIV),
    .SERVE_DELAY(SERVE_DELAY), .SCORE_MAX(SCORE_MAX), .SCORE_W(SCORE_W)
  ) dut (
    .VGA_CLOCK(clk), .RESET(rst_i), .START(start_i),
    .PADDLE_A_POSITION(pa_i), .PADDLE_B_POSITION(pb_i),
    .PIXEL_H(ph_i), .PIXEL_V(pv_i),
    .BALL_H(ball_h_o), .BALL_V(ball_v_o),
    .SCORE_A(score_a_o), .SCORE_B(score_b_o),
    .STATE(state_o), .PIXEL(pixel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_pad(input int raw);
    return (raw * 2 > VMAX - PADDLE_H) ? VMAX - PADDLE_H : raw * 2;
  endfunction

  function automatic int render(input int ph, input int pv);
    bit pad_a, pad_b, brd, ball, net;
    pad_a = ph >= PA_L && ph <= PA_R && pv >= m_pa && pv < m_pa + PADDLE_H;
    pad_b = ph >= PB_L && ph <= PB_R && pv >= m_pb && pv < m_pb + PADDLE_H;
    brd   = ph <= BORDER || ph >= HMAX || pv <= BORDER || pv >= VMAX;
    ball  = (m_st == 2 || m_st == 3) && ph >= m_bh && ph < m_bh + BALL_SIZE &&
            pv >= m_bv && pv < m_bv + BALL_SIZE;
    net   = ((pv / 16) % 2 == 1) && (ph == H_ACTIVE / 2 - 1 || ph == H_ACTIVE / 2);
    if (pad_a || pad_b) return 7;
    if (brd) return 4;
    if (ball) return 1;
    if (net) return 6;
    return 0;
  endfunction

  function automatic void score_point(input bit a_scores);
    int s;
    if (a_scores) begin
      m_sa = (m_sa + 1 > SCORE_MAX) ? SCORE_MAX : m_sa + 1;
      s = m_sa;
    end else begin
      m_sb = (m_sb + 1 > SCORE_MAX) ? SCORE_MAX : m_sb + 1;
      s = m_sb;
    end
    m_bh = CH;
    m_bv = CV;
    m_right = a_scores ? 1 : 0;
    if (s == SCORE_MAX) m_st = 3;
    else begin
      m_dly = SERVE_DELAY - 1;
      m_st = 1;
    end
  endfunction

  function automatic void ball_tick();
    int nbv, nd;
    nd = m_down;
    if (m_down == 1) begin
      if (m_bv + BALL_SIZE == VMAX - 1) begin nd = 0; nbv = m_bv - 1; end
      else nbv = m_bv + 1;
    end else begin
      if (m_bv == BORDER + 1) begin nd = 1; nbv = m_bv + 1; end
      else nbv = m_bv - 1;
    end
    if (m_right == 1) begin
      if (m_bh + BALL_SIZE == PB_L && m_bv + BALL_SIZE - 1 >= m_pb && m_bv <= m_pb + PADDLE_H - 1) begin
        m_right = 0; m_bh = m_bh - 1; m_bv = nbv; m_down = nd;
      end else if (m_bh + BALL_SIZE == HMAX) begin
        score_point(1'b1);
      end else begin
        m_bh = m_bh + 1; m_bv = nbv; m_down = nd;
      end
    end else begin
      if (m_bh == PA_R + 1 && m_bv + BALL_SIZE - 1 >= m_pa && m_bv <= m_pa + PADDLE_H - 1) begin
        m_right = 1; m_bh = m_bh + 1; m_bv = nbv; m_down = nd;
      end else if (m_bh == BORDER + 1) begin
        score_point(1'b0);
      end else begin
        m_bh = m_bh - 1; m_bv = nbv; m_down = nd;
      end
    end
  endfunction

  function automatic void model_step(input bit rst, input bit st, input int pa, input int pb,
                                     input int ph, input int pv);
    int pix;
    pix = render(ph, pv);
    if (rst) begin
      m_st = 0; m_sa = 0; m_sb = 0; m_bh = CH; m_bv = CV;
      m_right = 1; m_down = 1; m_step = 0; m_dly = 0; m_pix = 0;
    end else begin
      m_pix = pix;
      case (m_st)
        0: if (st) begin m_dly = SERVE_DELAY - 1; m_st = 1; end
        1: if (m_dly == 0) begin m_st = 2; m_step = 0; end else m_dly = m_dly - 1;
        2: if (m_step == STEP_DIV - 1) begin m_step = 0; ball_tick(); end
           else m_step = m_step + 1;
        default: if (st) begin
          m_sa = 0; m_sb = 0; m_bh = CH; m_bv = CV;
          m_dly = SERVE_DELAY - 1; m_st = 1;
        end
      endcase
    end
    m_pa = clamp_pad(pa);
    m_pb = clamp_pad(pb);
  endfunction

  // One clock: drive inputs, advance model, compare all outputs 1 time unit after the edge.
  task automatic cyc(input bit rst, input bit st, input int pa, input int pb, input int ph, input int pv);
    rst_i = rst; start_i = st;
    pa_i = 8'(pa); pb_i = 8'(pb); ph_i = 11'(ph); pv_i = 11'(pv);
    @(posedge clk);
    model_step(rst, st, pa, pb, ph, pv);
    #1;
    chk("state", int'(state_o), m_st);
    chk("ball_h", int'(ball_h_o), m_bh);
    chk("ball_v", int'(ball_v_o), m_bv);
    chk("score_a", int'(score_a_o), m_sa);
    chk("score_b", int'(score_b_o), m_sb);
    chk("pixel", int'(pixel_o), m_pix);
  endtask

  function automatic int rnd_h();
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 63));
  endfunction

  initial begin
    int pa, pb;
    bit done;
    rst_i = 1'b1; start_i = 1'b0; pa_i = '0; pb_i = '0; ph_i = '0; pv_i = '0;
    m_pa = 0; m_pb = 0;

    // Reset and the left border pixel.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 20);
    cyc(0, 0, 0, 0, 0, 20);
    chk("rst_state", int'(state_o), 0);
    chk("rst_ball_h", int'(ball_h_o), 31);
    chk("rst_ball_v", int'(ball_v_o), 23);
    chk("rst_scores", int'(score_a_o) + int'(score_b_o), 0);
    chk("rst_pixel_border", int'(pixel_o), 4);

    // Serve lasts exactly SERVE_DELAY cycles, first tick four clocks into play.
    cyc(0, 1, 0, 0, 10, 10);
    chk("serve_first", int'(state_o), 1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0, 10, 10);
      chk("serve_hold", int'(state_o), 1);
    end
    cyc(0, 0, 0, 0, 10, 10);
    chk("play_entry", int'(state_o), 2);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 10, 10);
    chk("first_tick_h", int'(ball_h_o), 32);
    chk("first_tick_v", int'(ball_v_o), 24);

    // Paddle clamp: input 255 limits paddle A to rows 37..44.
    cyc(0, 0, 255, 0, 0, 0);
    cyc(0, 0, 255, 0, PA_L, 37);
    chk("clamp_top_row", int'(pixel_o), 7);
    cyc(0, 0, 255, 0, PA_L, 44);
    chk("clamp_bot_row", int'(pixel_o), 7);
    cyc(0, 0, 255, 0, PA_L, 45);
    chk("clamp_border_row", int'(pixel_o), 4);

    // Play to game over with both paddles parked high.
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      cyc(0, 0, 0, 0, rnd_h(), $urandom_range(0, 47));
      if (m_st == 3) done = 1'b1;
    end
    chk("game_over_state", int'(state_o), 3);
    chk("game_over_score", (score_a_o > score_b_o) ? int'(score_a_o) : int'(score_b_o), SCORE_MAX);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, rnd_h(), $urandom_range(0, 47));
    cyc(0, 1, 0, 0, 5, 5);
    chk("restart_state", int'(state_o), 1);
    chk("restart_scores", int'(score_a_o) + int'(score_b_o), 0);
    chk("restart_ball_h", int'(ball_h_o), CH);

    // Reset during play restores everything on the next edge.
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 5, 5);
    chk("mid_play", int'(state_o), 2);
    cyc(1, 0, 0, 0, 5, 5);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_ball_h", int'(ball_h_o), 31);
    chk("midrst_ball_v", int'(ball_v_o), 23);
    chk("midrst_pixel", int'(pixel_o), 0);

    // Random play: slowly moving paddles, sparse START and RESET.
    pa = 10; pb = 10;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 63) == 0) pa = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 22));
      if ($urandom_range(0, 63) == 0) pb = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 22));
      cyc($urandom_range(0, 3999) == 0, $urandom_range(0, 49) == 0, pa, pb,
          rnd_h(), ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 47)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
